// File: rtl/dog_stage_if.sv
// Pixel stream bundle for dog_stage: enable, start-of-frame and both blur
// inputs in, registered difference with position tags out.
interface dog_stage_if;
  logic       clk_en;
  logic       sof;
  logic [7:0] din_a;
  logic [7:0] din_b;
  logic [8:0] dout;
  logic       dout_valid;
  logic [9:0] col;
  logic [9:0] row;
  logic       border;
  logic       eof;

  modport master (
    output clk_en, sof, din_a, din_b,
    input  dout, dout_valid, col, row, border, eof
  );

  modport slave (
    input  clk_en, sof, din_a, din_b,
    output dout, dout_valid, col, row, border, eof
  );
endinterface

// File: rtl/dog_stage.sv
// Difference-of-Gaussians stage: delays din_a by ALIGN enabled cycles, subtracts
// din_b and tags each result with its position, border and end-of-frame flags.
module dog_stage #(
  parameter int IMG_W  = 400,
  parameter int IMG_H  = 300,
  parameter int ALIGN  = 400,
  parameter int BORDER = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  dog_stage_if.slave  bus
);

  localparam int AW = (ALIGN > 1) ? $clog2(ALIGN) : 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [9:0]    prime_q;
  logic [9:0]    pcol_q;
  logic [9:0]    prow_q;
  logic [7:0]    mem_q [ALIGN];

  logic [8:0]    dout_q;
  logic          dout_valid_q;
  logic [9:0]    col_q;
  logic [9:0]    row_q;
  logic          border_q;
  logic          eof_q;

  logic [7:0]    delayed;
  logic          last_pix;
  logic          pix_border;
  logic          produce;

  assign delayed  = mem_q[ptr_q];
  assign last_pix = (pcol_q == 10'(IMG_W - 1)) && (prow_q == 10'(IMG_H - 1));
  assign pix_border = (int'(pcol_q) < BORDER) || (int'(pcol_q) >= IMG_W - BORDER) ||
                      (int'(prow_q) < BORDER) || (int'(prow_q) >= IMG_H - BORDER);

  // A sof aborts the pending pixel unless it is the last one of the frame.
  always_comb begin
    produce = 1'b0;
    if (bus.clk_en) begin
      case (state_q)
        StPrime: produce = (prime_q == 10'(ALIGN)) && (!bus.sof || last_pix);
        StRun:   produce = !bus.sof || last_pix;
        default: produce = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (bus.clk_en) begin
      mem_q[ptr_q] <= bus.din_a;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      prime_q      <= '0;
      pcol_q       <= '0;
      prow_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      border_q     <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (bus.clk_en) begin
        ptr_q <= (ptr_q == AW'(ALIGN - 1)) ? '0 : ptr_q + 1'b1;
        if (state_q == StPrime && prime_q != 10'(ALIGN)) begin
          prime_q <= prime_q + 10'd1;
        end
        if (produce) begin
          dout_q       <= {1'b0, delayed} - {1'b0, bus.din_b};
          dout_valid_q <= 1'b1;
          col_q        <= pcol_q;
          row_q        <= prow_q;
          border_q     <= pix_border;
          eof_q        <= last_pix;
          if (last_pix) begin
            pcol_q  <= '0;
            prow_q  <= '0;
            state_q <= StIdle;
          end else begin
            state_q <= StRun;
            if (pcol_q == 10'(IMG_W - 1)) begin
              pcol_q <= '0;
              prow_q <= prow_q + 10'd1;
            end else begin
              pcol_q <= pcol_q + 10'd1;
            end
          end
        end
        // The sof cycle itself is priming cycle 0, so the count resumes at 1.
        if (bus.sof) begin
          state_q <= StPrime;
          prime_q <= 10'd1;
          pcol_q  <= '0;
          prow_q  <= '0;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.border     = border_q;
  assign bus.eof        = eof_q;

endmodule

// File: tb/tb_dog_stage.sv
// Randomised and directed bench for dog_stage against a per-enabled-cycle
// frame model built from the pixel-timing rules.
module tb_dog_stage;
  localparam int W = 4;
  localparam int H = 3;
  localparam int ALIGN = 5;
  localparam int B = 1;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dog_stage_if bus ();

  dog_stage #(.IMG_W(W), .IMG_H(H), .ALIGN(ALIGN), .BORDER(B)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: every enabled din_a ever seen, plus the sof index of the live frame.
  int   a_hist[$];
  bit   active = 1'b0;
  int   t0 = 0;
  logic [8:0] exp_dout = '0;
  logic [9:0] exp_col = '0;
  logic [9:0] exp_row = '0;
  logic       exp_border = 1'b0;
  logic       exp_eof = 1'b0;

  int obs_pulses, obs_eofs, obs_inner, obs_neg, obs_pos;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_tally();
    obs_pulses = 0; obs_eofs = 0; obs_inner = 0; obs_neg = 0; obs_pos = 0;
  endtask

  task automatic step(input logic en, input logic s, input logic [7:0] a, input logic [7:0] b);
    int e, n;
    logic exp_v;
    @(negedge clk);
    bus.clk_en = en; bus.sof = s; bus.din_a = a; bus.din_b = b;
    exp_v = 1'b0;
    if (en) begin
      e = a_hist.size();
      a_hist.push_back(int'(a));
      n = e - t0 - ALIGN;
      if (active && n >= 0 && (!s || n == NPIX - 1)) begin
        exp_v      = 1'b1;
        exp_dout   = 9'(a_hist[e - ALIGN] - int'(b));
        exp_col    = 10'(n % W);
        exp_row    = 10'(n / W);
        exp_border = ((n % W) < B) || ((n % W) >= W - B) || ((n / W) < B) || ((n / W) >= H - B);
        exp_eof    = (n == NPIX - 1);
        if (n == NPIX - 1) active = 1'b0;
      end
      if (s) begin
        active = 1'b1;
        t0 = e;
      end
    end
    @(posedge clk);
    #1;
    check_eq("dout_valid", 32'(bus.dout_valid), 32'(exp_v));
    check_eq("dout", 32'(bus.dout), 32'(exp_dout));
    check_eq("col", 32'(bus.col), 32'(exp_col));
    check_eq("row", 32'(bus.row), 32'(exp_row));
    check_eq("border", 32'(bus.border), 32'(exp_border));
    check_eq("eof", 32'(bus.eof), 32'(exp_eof));
    if (bus.dout_valid) begin
      obs_pulses++;
      if (bus.eof) obs_eofs++;
      if (!bus.border) obs_inner++;
      if (bus.dout == 9'h101) obs_neg++;
      if (bus.dout == 9'h0ff) obs_pos++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.clk_en = 1'b0;
    bus.sof = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    check_eq("rst_valid", 32'(bus.dout_valid), 32'd0);
    check_eq("rst_col", 32'(bus.col), 32'd0);
    check_eq("rst_row", 32'(bus.row), 32'd0);
    check_eq("rst_border", 32'(bus.border), 32'd0);
    check_eq("rst_eof", 32'(bus.eof), 32'd0);
    active = 1'b0;
    exp_dout = '0; exp_col = '0; exp_row = '0; exp_border = 1'b0; exp_eof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] delayed_inv();
    int sz = a_hist.size();
    if (sz >= ALIGN && a_hist[sz - ALIGN] == 0) return 8'd255;
    return 8'd0;
  endfunction

  initial begin
    logic [7:0] a;
    bus.clk_en = 1'b0; bus.sof = 1'b0; bus.din_a = '0; bus.din_b = '0;
    clear_tally();
    do_reset();

    // Idle traffic without sof must produce nothing.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));

    // Constant frame: +60 everywhere, 12 pulses, one eof, two interior pixels.
    clear_tally();
    step(1'b1, 1'b1, 8'd100, 8'd40);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'd100, 8'd40);
    check_eq("const_pulses", 32'(obs_pulses), 32'd12);
    check_eq("const_eofs", 32'(obs_eofs), 32'd1);
    check_eq("const_inner", 32'(obs_inner), 32'd2);

    // Gapped enable: same frame structure, pulses only after enabled cycles.
    clear_tally();
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 1; i < 40; i++) step(1'((i % 2) == 0), 1'b0, 8'($urandom), 8'($urandom));
    check_eq("gap_pulses", 32'(obs_pulses), 32'd12);
    check_eq("gap_eofs", 32'(obs_eofs), 32'd1);

    // Full-scale differences in both directions.
    clear_tally();
    step(1'b1, 1'b1, 8'd0, 8'd0);
    for (int i = 1; i < 20; i++) begin
      a = (i % 2) ? 8'd255 : 8'd0;
      step(1'b1, 1'b0, a, delayed_inv());
    end
    check_eq("neg255_seen", 32'(obs_neg > 0), 32'd1);
    check_eq("pos255_seen", 32'(obs_pos > 0), 32'd1);

    // Abort at pixel 6: no eof for the first frame, full restart follows.
    clear_tally();
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 1; i < 11; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    check_eq("abort_pulses", 32'(obs_pulses), 32'd18);
    check_eq("abort_eofs", 32'(obs_eofs), 32'd1);

    // sof coinciding with the last pixel: eof kept, next frame primes at once.
    clear_tally();
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    check_eq("lastsof_pulses", 32'(obs_pulses), 32'd24);
    check_eq("lastsof_eofs", 32'(obs_eofs), 32'd2);

    // Reset mid-frame, then silence until a fresh sof.
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    do_reset();
    clear_tally();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    check_eq("post_rst_quiet", 32'(obs_pulses), 32'd0);
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    check_eq("post_rst_pulses", 32'(obs_pulses), 32'd12);

    // Random enable, sof and data.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(39, 0) == 0),
           8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dog_stage.md
DOG_STAGE -- requirements
Module: dog_stage

Interface
REQ-001 Parameter IMG_W, default 400, pixels per row.
REQ-002 Parameter IMG_H, default 300, rows per frame.
REQ-003 Parameter ALIGN, default 400, enabled-cycle lead of din_a over din_b; legal range 1..1023.
REQ-004 Parameter BORDER, default 4, border width in pixels flagged on each edge.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 Clk_en  input  1  pixel advance; when low all state holds.
REQ-008 sof  input  1  start of frame; marks pixel (0,0) on din_a; sampled only when Clk_en=1.
REQ-009 din_a  input  8  less-blurred pixel stream, unsigned.
REQ-010 din_b  input  8  more-blurred pixel stream, unsigned; same pixel arrives ALIGN enabled cycles after din_a.
REQ-011 dout  output  9  signed two's-complement difference, delayed din_a minus din_b.
REQ-012 dout_valid  output  1  dout, col, row, border and eof are valid.
REQ-013 col  output  10  column of current output pixel.
REQ-014 row  output  10  row of current output pixel.
REQ-015 border  output  1  output pixel lies within BORDER of any image edge.
REQ-016 eof  output  1  high with the last pixel of the frame.

Function
REQ-017 Delay line SHALL be a circular buffer of ALIGN x 8 bits, written with din_a on every enabled cycle in all states, read-before-write at the same address, pointer wrapping from ALIGN-1 to 0.
REQ-018 Delayed sample SHALL equal the din_a captured exactly ALIGN enabled cycles earlier.
REQ-019 States: IDLE, PRIME, RUN; all transitions only on enabled cycles.
REQ-020 IDLE -> PRIME on sof; PRIME counts ALIGN enabled cycles, the sof cycle counting as cycle 0.
REQ-021 With sof on enabled cycle t0, the enabled cycle t0+ALIGN+n SHALL produce output pixel n (n = 0..IMG_W*IMG_H-1); state is RUN from pixel 0 onward.
REQ-022 Output pixel n: dout = delayed din_a - din_b, computed at 9 bits with no saturation (range -255..+255).
REQ-023 All outputs SHALL be registered, appearing the clock after the producing enabled cycle; latency 1 clock.
REQ-024 dout_valid SHALL be a one-clock pulse per output pixel, low on every clock that does not follow an output-producing enabled cycle; other outputs hold their last value.
REQ-025 col increments per output and wraps IMG_W-1 -> 0, at which point row increments; row and col start at 0 for pixel 0.
REQ-026 border = (col < BORDER) or (col >= IMG_W-BORDER) or (row < BORDER) or (row >= IMG_H-BORDER).
REQ-027 eof SHALL accompany pixel IMG_W*IMG_H-1; state returns to IDLE on that enabled cycle.
REQ-028 sof in PRIME or RUN SHALL abort the current frame with no eof, clear counters, and restart PRIME at that cycle.
REQ-029 sof on the enabled cycle producing the last pixel: last pixel and eof are emitted, then PRIME starts from that cycle.
REQ-030 din_a/din_b SHALL be ignored for output purposes in IDLE; no output without a preceding sof.

Reset
REQ-031 Reset_n low SHALL immediately force state IDLE, dout=0, dout_valid=0, col=0, row=0, border=0, eof=0, buffer pointer 0.
REQ-032 Buffer contents need no reset; the first ALIGN reads after sof are never output.
REQ-033 Reset release SHALL need no further setup; the block waits in IDLE for sof.

Verification (IMG_W=4, IMG_H=3, ALIGN=5, BORDER=1)
REQ-034 Reset_n low mid-stream -> all outputs 0 at once; no dout_valid until a new sof plus 5 enabled cycles.
REQ-035 Clk_en=1, sof at t0, din_a=100, din_b=40 -> 12 dout_valid pulses, first one clock after t0+5, dout=+60, eof on the 12th only.
REQ-036 din_a=0/din_b=255, then din_a=255/din_b=0 -> dout=-255 (0x101) and +255 (0x0FF).
REQ-037 Same frame with Clk_en toggling 1,0,1,0 -> identical dout/col/row sequence; dout_valid only after enabled cycles.
REQ-038 sof re-asserted at output pixel 6 -> no eof; next output (0,0) 5 enabled cycles later; full 12 outputs follow.
REQ-039 Border check -> border=0 only at (row1,col1) and (row1,col2); 1 on the other 10 pixels.
